// File: rtl/glitch_sequencer.sv
// Clock-glitch sequencer: divides MCLK into the target MCU clock, aligns target reset to it,
// and glitches a programmed burst of MCU periods a set number of cycles after reset release.
module glitch_sequencer #(
   parameter int unsigned DIVISOR = 16,
   parameter int unsigned PH_W    = 8,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned BURST_W = 4
) (
   input  logic               MCLK,
   input  logic               RST,
   input  logic               TGT_NRST_IN,
   input  logic               ARM,
   input  logic               ABORT,
   input  logic [CNT_W-1:0]   CFG_DELAY,
   input  logic [BURST_W-1:0] CFG_BURST,
   input  logic [PH_W-1:0]    CFG_START,
   input  logic [PH_W-1:0]    CFG_STOP,
   input  logic [1:0]         CFG_MODE,
   output logic               MCU_CLK,
   output logic               MCU_NRST,
   output logic               TRIG,
   output logic               BUSY,
   output logic               DONE
);

   localparam logic [PH_W-1:0] PH_LAST = PH_W'(DIVISOR - 1);
   localparam logic [PH_W-1:0] PH_HALF = PH_W'(DIVISOR / 2);
   localparam logic [PH_W-1:0] PH_FALL = PH_W'(DIVISOR / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_COUNT,
      S_BURST,
      S_DONE
   } state_e;

   state_e             state_q, state_d;
   logic [PH_W-1:0]    ph_q, ph_d;
   logic [1:0]         sync_q, sync_d;
   logic               mcu_clk_q, mcu_clk_d;
   logic               mcu_nrst_q, mcu_nrst_d;
   logic               trig_q, trig_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BURST_W-1:0] bcnt_q, bcnt_d;
   logic [CNT_W-1:0]   delay_q, delay_d;
   logic [BURST_W-1:0] burst_q, burst_d;
   logic [PH_W-1:0]    start_q, start_d;
   logic [PH_W-1:0]    stop_q, stop_d;
   logic [1:0]         mode_q, mode_d;

   logic pe;
   logic clk_b;
   logic win;

   assign pe    = (ph_q == PH_LAST);
   assign clk_b = (ph_q < PH_HALF);
   assign win   = (state_q == S_BURST) && (ph_q >= start_q) && (ph_q <= stop_q);

   // Phase counter, reset synchroniser, clock shaping and sequencing FSM
   always_comb begin
      ph_d       = pe ? '0 : ph_q + PH_W'(1);
      sync_d     = {sync_q[0], TGT_NRST_IN};
      mcu_nrst_d = (ph_q == PH_FALL) ? sync_q[1] : mcu_nrst_q;
      state_d    = state_q;
      cnt_d      = cnt_q;
      bcnt_d     = bcnt_q;
      delay_d    = delay_q;
      burst_d    = burst_q;
      start_d    = start_q;
      stop_d     = stop_q;
      mode_d     = mode_q;

      mcu_clk_d = clk_b;
      if (win) begin
         case (mode_q)
            2'd0:    mcu_clk_d = ~clk_b;
            2'd1:    mcu_clk_d = 1'b1;
            2'd2:    mcu_clk_d = 1'b0;
            default: mcu_clk_d = clk_b;
         endcase
      end

      if (ABORT) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (ARM) begin
                  delay_d = CFG_DELAY;
                  burst_d = CFG_BURST;
                  start_d = CFG_START;
                  stop_d  = CFG_STOP;
                  mode_d  = CFG_MODE;
                  state_d = S_WAIT_LOW;
               end
            end
            S_WAIT_LOW: begin
               if (!mcu_nrst_q) state_d = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
               if (mcu_nrst_q) begin
                  cnt_d   = '0;
                  state_d = S_COUNT;
               end
            end
            S_COUNT: begin
               if (!mcu_nrst_q) begin
                  state_d = S_WAIT_HIGH;
               end else if (pe) begin
                  if (cnt_q == delay_q) begin
                     bcnt_d  = (burst_q == '0) ? BURST_W'(1) : burst_q;
                     state_d = S_BURST;
                  end else if (cnt_q != '1) begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            S_BURST: begin
               if (!mcu_nrst_q) begin
                  state_d = S_WAIT_HIGH;
               end else if (pe) begin
                  if (bcnt_q <= BURST_W'(1)) state_d = S_DONE;
                  else                       bcnt_d  = bcnt_q - BURST_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      // Status outputs are registered views of the next state
      trig_d = (state_d == S_BURST);
      busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge MCLK or posedge RST) begin
      if (RST) begin
         state_q    <= S_IDLE;
         ph_q       <= '0;
         sync_q     <= '0;
         mcu_clk_q  <= 1'b0;
         mcu_nrst_q <= 1'b0;
         trig_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cnt_q      <= '0;
         bcnt_q     <= '0;
         delay_q    <= '0;
         burst_q    <= '0;
         start_q    <= '0;
         stop_q     <= '0;
         mode_q     <= '0;
      end else begin
         state_q    <= state_d;
         ph_q       <= ph_d;
         sync_q     <= sync_d;
         mcu_clk_q  <= mcu_clk_d;
         mcu_nrst_q <= mcu_nrst_d;
         trig_q     <= trig_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cnt_q      <= cnt_d;
         bcnt_q     <= bcnt_d;
         delay_q    <= delay_d;
         burst_q    <= burst_d;
         start_q    <= start_d;
         stop_q     <= stop_d;
         mode_q     <= mode_d;
      end
   end

   assign MCU_CLK  = mcu_clk_q;
   assign MCU_NRST = mcu_nrst_q;
   assign TRIG     = trig_q;
   assign BUSY     = busy_q;
   assign DONE     = done_q;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Bench for glitch_sequencer: directed scenarios plus randomized runs, all checked against
// a period-arithmetic reference model of the sequencer.
module tb_glitch_sequencer;

   localparam int unsigned DIVISOR = 16;
   localparam int unsigned PH_W    = 8;
   localparam int unsigned CNT_W   = 16;
   localparam int unsigned BURST_W = 4;

   localparam int ST_IDLE = 0;
   localparam int ST_WL   = 1;
   localparam int ST_WH   = 2;
   localparam int ST_RUN  = 3;
   localparam int ST_DONE = 4;

   logic               MCLK = 1'b0;
   logic               RST = 1'b1;
   logic               TGT_NRST_IN = 1'b1;
   logic               ARM = 1'b0;
   logic               ABORT = 1'b0;
   logic [CNT_W-1:0]   CFG_DELAY = '0;
   logic [BURST_W-1:0] CFG_BURST = '0;
   logic [PH_W-1:0]    CFG_START = '0;
   logic [PH_W-1:0]    CFG_STOP = '0;
   logic [1:0]         CFG_MODE = '0;
   logic               MCU_CLK, MCU_NRST, TRIG, BUSY, DONE;

   int vectors = 0;
   int miscompares = 0;

   glitch_sequencer #(
      .DIVISOR(DIVISOR), .PH_W(PH_W), .CNT_W(CNT_W), .BURST_W(BURST_W)
   ) dut (
      .MCLK(MCLK), .RST(RST), .TGT_NRST_IN(TGT_NRST_IN), .ARM(ARM), .ABORT(ABORT),
      .CFG_DELAY(CFG_DELAY), .CFG_BURST(CFG_BURST), .CFG_START(CFG_START),
      .CFG_STOP(CFG_STOP), .CFG_MODE(CFG_MODE),
      .MCU_CLK(MCU_CLK), .MCU_NRST(MCU_NRST), .TRIG(TRIG), .BUSY(BUSY), .DONE(DONE)
   );

   always #5 MCLK = ~MCLK;

   // Reference model: burst position is computed as absolute MCU period numbers
   int   m_n, m_st, m_bfirst, m_blast;
   int   m_delay, m_burst, m_start, m_stop, m_mode;
   logic m_s1, m_s2, m_nrst;
   logic e_clk, e_nrst, e_trig, e_busy, e_done;

   initial forever begin
      int   ph, per, f;
      logic clkb, win, old_nrst;
      @(posedge MCLK or posedge RST);
      if (RST) begin
         m_n = 0; m_st = ST_IDLE; m_bfirst = 0; m_blast = 0;
         m_delay = 0; m_burst = 0; m_start = 0; m_stop = 0; m_mode = 0;
         m_s1 = 1'b0; m_s2 = 1'b0; m_nrst = 1'b0;
         e_clk = 1'b0; e_nrst = 1'b0; e_trig = 1'b0; e_busy = 1'b0; e_done = 1'b0;
      end else begin
         ph   = m_n % DIVISOR;
         per  = m_n / DIVISOR;
         clkb = (ph < DIVISOR / 2);
         win  = (m_st == ST_RUN) && (per >= m_bfirst) && (ph >= m_start) && (ph <= m_stop);
         if (!win)             e_clk = clkb;
         else if (m_mode == 0) e_clk = !clkb;
         else if (m_mode == 1) e_clk = 1'b1;
         else if (m_mode == 2) e_clk = 1'b0;
         else                  e_clk = clkb;
         old_nrst = m_nrst;
         if (ph == DIVISOR / 2 - 1) m_nrst = m_s2;
         m_s2 = m_s1;
         m_s1 = TGT_NRST_IN;
         if (ABORT) begin
            m_st = ST_IDLE;
         end else if ((m_st == ST_IDLE || m_st == ST_DONE) && ARM) begin
            m_delay = int'(CFG_DELAY); m_burst = int'(CFG_BURST);
            m_start = int'(CFG_START); m_stop = int'(CFG_STOP); m_mode = int'(CFG_MODE);
            m_st = ST_WL;
         end else if (m_st == ST_WL && !old_nrst) begin
            m_st = ST_WH;
         end else if (m_st == ST_WH && old_nrst) begin
            f        = (m_n + 1) / DIVISOR;
            m_bfirst = f + m_delay + 1;
            m_blast  = m_bfirst + ((m_burst == 0) ? 1 : m_burst) - 1;
            m_st     = ST_RUN;
         end else if (m_st == ST_RUN) begin
            if (!old_nrst) m_st = ST_WH;
            else if (per == m_blast && ph == DIVISOR - 1) m_st = ST_DONE;
         end
         m_n++;
         e_nrst = m_nrst;
         e_trig = (m_st == ST_RUN) && ((m_n / DIVISOR) >= m_bfirst);
         e_busy = (m_st == ST_WL) || (m_st == ST_WH) || (m_st == ST_RUN);
         e_done = (m_st == ST_DONE);
      end
   end

   task automatic arm(input int d, input int b, input int st, input int sp, input int md);
      @(negedge MCLK);
      CFG_DELAY = CNT_W'(d);
      CFG_BURST = BURST_W'(b);
      CFG_START = PH_W'(st);
      CFG_STOP  = PH_W'(sp);
      CFG_MODE  = 2'(md);
      ARM = 1'b1;
      @(negedge MCLK);
      ARM = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      #12;
      vectors++;
      if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== 5'b0) begin
         miscompares++;
         $display("FAIL reset_values got=%b exp=00000", {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE});
      end
      @(negedge MCLK);
      RST = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge MCLK);
         vectors++;
         if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL reset_release cyc=%0d got=%b exp=%b", i,
                     {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
         end
      end
   endtask

   task automatic test_idle_clock();
      logic smp [48];
      int   r, hi, lo, lat;
      for (int i = 0; i < 48; i++) begin
         @(negedge MCLK);
         vectors++;
         if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL idle_clock cyc=%0d got=%b exp=%b", i,
                     {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
         end
         smp[i] = MCU_CLK;
      end
      r = -1; hi = 0; lo = 0;
      for (int k = 1; k < 32; k++) if (r < 0 && !smp[k-1] && smp[k]) r = k;
      if (r >= 0) begin
         for (int k = r; k < 48 && smp[k]; k++) hi++;
         for (int k = r + hi; k < 48 && !smp[k]; k++) lo++;
      end
      vectors++;
      if (hi !== DIVISOR / 2) begin
         miscompares++;
         $display("FAIL idle_clock_high got=%0d exp=%0d", hi, DIVISOR / 2);
      end
      vectors++;
      if (lo !== DIVISOR / 2) begin
         miscompares++;
         $display("FAIL idle_clock_low got=%0d exp=%0d", lo, DIVISOR / 2);
      end
      for (int pass = 0; pass < 2; pass++) begin
         TGT_NRST_IN = (pass == 1);
         lat = -1;
         for (int i = 1; i <= 30; i++) begin
            @(negedge MCLK);
            vectors++;
            if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
               miscompares++;
               $display("FAIL nrst_follow cyc=%0d got=%b exp=%b", i,
                        {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
            end
            if (lat < 0 && MCU_NRST === TGT_NRST_IN) lat = i;
         end
         vectors++;
         if (lat < 3 || lat > 2 + DIVISOR) begin
            miscompares++;
            $display("FAIL nrst_latency level=%0d got=%0d exp=3..%0d", pass, lat, 2 + DIVISOR);
         end
      end
   endtask

   // Arm, pulse target reset, run to DONE and measure the burst
   task automatic test_burst_case(input string name, input int d, input int b, input int st,
                                  input int sp, input int md, input int exp_trig, input int exp_high);
      int   trig_cnt, high_cnt, nrst_rise, trig_rise;
      logic prev_nrst, prev_trig, got_done;
      arm(d, b, st, sp, md);
      trig_cnt = 0; high_cnt = 0; nrst_rise = -1; trig_rise = -1;
      prev_nrst = MCU_NRST; prev_trig = TRIG; got_done = 1'b0;
      for (int i = 0; i < 700 && !got_done; i++) begin
         @(negedge MCLK);
         vectors++;
         if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%b exp=%b", name, i,
                     {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
         end
         if (!prev_nrst && MCU_NRST) nrst_rise = i;
         if (!prev_trig && TRIG && trig_rise < 0) trig_rise = i;
         if (TRIG) begin
            trig_cnt++;
            if (MCU_CLK) high_cnt++;
         end
         prev_nrst = MCU_NRST; prev_trig = TRIG;
         got_done = DONE;
         TGT_NRST_IN = !(i >= 2 && i < 42);
      end
      TGT_NRST_IN = 1'b1;
      vectors++;
      if (got_done !== 1'b1) begin
         miscompares++;
         $display("FAIL %s_done got=%b exp=1 (timeout)", name, got_done);
      end
      vectors++;
      if (trig_cnt !== exp_trig) begin
         miscompares++;
         $display("FAIL %s_trig_len got=%0d exp=%0d", name, trig_cnt, exp_trig);
      end
      vectors++;
      if (high_cnt !== exp_high) begin
         miscompares++;
         $display("FAIL %s_clk_high got=%0d exp=%0d", name, high_cnt, exp_high);
      end
      vectors++;
      if (trig_rise - nrst_rise !== DIVISOR * d + DIVISOR / 2) begin
         miscompares++;
         $display("FAIL %s_lead got=%0d exp=%0d", name, trig_rise - nrst_rise, DIVISOR * d + DIVISOR / 2);
      end
   endtask

   task automatic test_glitch_basic();
      test_burst_case("glitch_basic", 5, 1, 2, 5, 0, 16, 4);
   endtask

   task automatic test_burst_len();
      test_burst_case("burst3_low", 2, 3, 0, 7, 2, 48, 0);
      test_burst_case("burst0_low", 1, 0, 0, 7, 2, 16, 0);
   endtask

   task automatic test_empty_window();
      test_burst_case("empty_window", 1, 1, 9, 3, 0, 16, 8);
      test_burst_case("dry_run", 0, 1, 0, 15, 3, 16, 8);
   endtask

   task automatic test_midrun_reset();
      int   trig_cnt, nrst_rise, trig_rise, second_at;
      logic prev_nrst, prev_trig, got_done;
      arm(6, 1, 0, 15, 2);
      trig_cnt = 0; nrst_rise = -1; trig_rise = -1; second_at = -1;
      prev_nrst = MCU_NRST; prev_trig = TRIG; got_done = 1'b0;
      for (int i = 0; i < 900 && !got_done; i++) begin
         @(negedge MCLK);
         vectors++;
         if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
            miscompares++;
            $display("FAIL midrun cyc=%0d got=%b exp=%b", i,
                     {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
         end
         if (!prev_nrst && MCU_NRST) begin
            nrst_rise = i;
            if (second_at < 0) second_at = i + 3 * DIVISOR + 12;
         end
         if (!prev_trig && TRIG && trig_rise < 0) trig_rise = i;
         if (TRIG) trig_cnt++;
         if (second_at >= 0 && i == second_at + 28) begin
            vectors++;
            if ({TRIG, BUSY, MCU_NRST} !== 3'b010) begin
               miscompares++;
               $display("FAIL midrun_wait_high trig/busy/nrst got=%b exp=010", {TRIG, BUSY, MCU_NRST});
            end
         end
         prev_nrst = MCU_NRST; prev_trig = TRIG;
         got_done = DONE;
         TGT_NRST_IN = !((i >= 2 && i < 42) || (second_at >= 0 && i >= second_at && i < second_at + 30));
      end
      TGT_NRST_IN = 1'b1;
      vectors++;
      if (got_done !== 1'b1 || trig_cnt !== 16) begin
         miscompares++;
         $display("FAIL midrun_done done=%b trig_len=%0d exp done=1 trig_len=16", got_done, trig_cnt);
      end
      vectors++;
      if (trig_rise - nrst_rise !== DIVISOR * 6 + DIVISOR / 2) begin
         miscompares++;
         $display("FAIL midrun_recount got=%0d exp=%0d", trig_rise - nrst_rise, DIVISOR * 6 + DIVISOR / 2);
      end
   endtask

   task automatic test_abort();
      for (int pass = 0; pass < 2; pass++) begin
         int trig_seen;
         arm(1, 8, 0, 15, 0);
         trig_seen = 0;
         for (int i = 0; i < 400 && trig_seen < 4; i++) begin
            @(negedge MCLK);
            vectors++;
            if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
               miscompares++;
               $display("FAIL abort_setup cyc=%0d got=%b exp=%b", i,
                        {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
            end
            if (TRIG) trig_seen++;
            TGT_NRST_IN = !(i >= 2 && i < 42);
         end
         TGT_NRST_IN = 1'b1;
         if (pass == 0) begin
            ABORT = 1'b1;
            @(negedge MCLK);
            ABORT = 1'b0;
            vectors++;
            if ({TRIG, BUSY, DONE} !== 3'b000) begin
               miscompares++;
               $display("FAIL abort_idle trig/busy/done got=%b exp=000", {TRIG, BUSY, DONE});
            end
         end else begin
            #2 RST = 1'b1;
            #1;
            vectors++;
            if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== 5'b0) begin
               miscompares++;
               $display("FAIL rst_midburst got=%b exp=00000", {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE});
            end
            @(negedge MCLK);
            RST = 1'b0;
         end
         for (int i = 0; i < 40; i++) begin
            @(negedge MCLK);
            vectors++;
            if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
               miscompares++;
               $display("FAIL abort_after pass=%0d cyc=%0d got=%b exp=%b", pass, i,
                        {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
            end
         end
      end
   endtask

   task automatic test_random();
      for (int it = 0; it < 25; it++) begin
         int d, b, a, w, a2, w2, len;
         d = $urandom_range(0, 5);
         b = $urandom_range(0, 4);
         arm(d, b, $urandom_range(0, 17), $urandom_range(0, 17), $urandom_range(0, 3));
         a  = $urandom_range(0, 20);
         w  = $urandom_range(1, 40);
         a2 = ($urandom_range(0, 2) == 0) ? a + w + $urandom_range(10, 120) : -1;
         w2 = $urandom_range(1, 30);
         len = DIVISOR * (d + b + 8) + 80;
         for (int i = 0; i < len; i++) begin
            @(negedge MCLK);
            vectors++;
            if ({MCU_CLK, MCU_NRST, TRIG, BUSY, DONE} !== {e_clk, e_nrst, e_trig, e_busy, e_done}) begin
               miscompares++;
               $display("FAIL random it=%0d cyc=%0d got=%b exp=%b", it, i,
                        {MCU_CLK, MCU_NRST, TRIG, BUSY, DONE}, {e_clk, e_nrst, e_trig, e_busy, e_done});
            end
            TGT_NRST_IN = !((i >= a && i < a + w) || (a2 >= 0 && i >= a2 && i < a2 + w2));
            ARM   = ($urandom_range(0, 99) == 0);
            ABORT = ($urandom_range(0, 299) == 0);
            if (ARM) begin
               CFG_DELAY = CNT_W'($urandom_range(0, 5));
               CFG_BURST = BURST_W'($urandom_range(0, 4));
               CFG_START = PH_W'($urandom_range(0, 17));
               CFG_STOP  = PH_W'($urandom_range(0, 17));
               CFG_MODE  = 2'($urandom_range(0, 3));
            end
         end
         @(negedge MCLK);
         ARM = 1'b0;
         ABORT = 1'b1;
         TGT_NRST_IN = 1'b1;
         @(negedge MCLK);
         ABORT = 1'b0;
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog expired after %0d vectors", vectors);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle_clock();
      test_glitch_basic();
      test_burst_len();
      test_empty_window();
      test_midrun_reset();
      test_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
